alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with a registered response slot.
// Latency: one cycle from accept to rsp_valid; one operation per cycle sustained while rsp_ready is high.
// Backpressure: requests stall (reqN_ready=0) while the response slot is full and not draining.
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie and no last-grant state exists.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        alu_enable,
   output logic [3:0]  alu_operation,
   output logic [31:0] alu_operand_a,
   output logic [31:0] alu_operand_b,
   input  logic [31:0] alu_result,
   input  logic        alu_result_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

   rsp_state_e  state_q, state_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_zero_q, rsp_zero_d;
   logic        gnt_vld;
   logic        gnt_idx;
   logic        can_accept;
   logic        accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic        last_grant_q, last_grant_d;
`endif

   // Pick the requester to grant this cycle from those presenting valid.
   always_comb begin
      gnt_vld = req0_valid | req1_valid;
      gnt_idx = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (!req0_valid && req1_valid) begin
         gnt_idx = 1'b1;
      end
`else
      if (req0_valid && req1_valid) begin
         gnt_idx = ~last_grant_q;
      end else if (req1_valid) begin
         gnt_idx = 1'b1;
      end
`endif
   end

   // No accept can happen while reset is asserted, even though the slot reads empty.
   assign can_accept = rst_n && ((state_q == ST_EMPTY) || rsp_ready);
   assign accept     = gnt_vld && can_accept;
   assign req0_ready = accept && !gnt_idx;
   assign req1_ready = accept && gnt_idx;

   // Drive the shared ALU only with an operation that is being accepted this cycle.
   always_comb begin
      alu_enable    = 1'b0;
      alu_operation = 4'd0;
      alu_operand_a = 32'd0;
      alu_operand_b = 32'd0;
      if (accept) begin
         alu_enable    = 1'b1;
         alu_operation = gnt_idx ? req1_op : req0_op;
         alu_operand_a = gnt_idx ? req1_a  : req0_a;
         alu_operand_b = gnt_idx ? req1_b  : req0_b;
      end
   end

   // Response slot next state: load on accept, empty on drain without a refill.
   always_comb begin
      state_d      = state_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (accept) begin
               state_d = ST_FULL;
            end else if (rsp_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (accept) begin
         rsp_id_d     = gnt_idx;
         rsp_result_d = alu_result;
         rsp_zero_d   = alu_result_zero;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Round-robin pointer moves only when a grant is actually taken.
   always_comb begin
      last_grant_d = accept ? gnt_idx : last_grant_q;
   end

   // Round-robin pointer register; reset value lets requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Response slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 32'd0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign rsp_valid  = (state_q == ST_FULL);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by randomized traffic.
// A behavioural ALU is attached to the ALU ports; a transaction-level model predicts every output.
// Honours ALU_ARB_FIXED_PRIO_EN for tie-break expectations.
module tb_alu_arbiter;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        alu_enable;
   logic [3:0]  alu_operation;
   logic [31:0] alu_operand_a, alu_operand_b;
   logic [31:0] alu_result;
   logic        alu_result_zero;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [31:0] rsp_result;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: response slot contents and round-robin pointer.
   bit          m_full;
   bit          m_id;
   logic [31:0] m_res;
   bit          m_zero;
   bit          m_last;
   bit          acc0, acc1;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_enable(alu_enable), .alu_operation(alu_operation),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_result(alu_result), .alu_result_zero(alu_result_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // Behavioural shared ALU.
   always_comb begin
      alu_result      = alu_fn(alu_operation, alu_operand_a, alu_operand_b);
      alu_result_zero = (alu_result == 32'd0);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0; m_id = 1'b0; m_res = 32'd0; m_zero = 1'b0; m_last = 1'b1;
      acc0 = 1'b0; acc1 = 1'b0;
   endtask

   // One clock cycle: entered at a falling edge with inputs already driven.
   task automatic step();
      bit          can, g_vld, g;
      logic [3:0]  eop;
      logic [31:0] ea, eb, nres;
      #1;
      can   = rst_n && (!m_full || rsp_ready);
      g_vld = req0_valid || req1_valid;
      if (req0_valid && req1_valid) g = FIXED_PRIO ? 1'b0 : !m_last;
      else                          g = !req0_valid;
      acc0 = can && g_vld && !g;
      acc1 = can && g_vld && g;
      eop  = acc0 ? req0_op : (acc1 ? req1_op : 4'd0);
      ea   = acc0 ? req0_a  : (acc1 ? req1_a  : 32'd0);
      eb   = acc0 ? req0_b  : (acc1 ? req1_b  : 32'd0);
      check_val("req0_ready", 32'(req0_ready), 32'(acc0));
      check_val("req1_ready", 32'(req1_ready), 32'(acc1));
      check_val("alu_enable", 32'(alu_enable), 32'(acc0 || acc1));
      check_val("alu_operation", 32'(alu_operation), 32'(eop));
      check_val("alu_operand_a", alu_operand_a, ea);
      check_val("alu_operand_b", alu_operand_b, eb);
      nres = alu_fn(eop, ea, eb);
      @(posedge clk);
      if (acc0 || acc1) begin
         m_full = 1'b1; m_id = acc1; m_res = nres; m_zero = (nres == 32'd0); m_last = acc1;
      end else if (m_full && rsp_ready && rst_n) begin
         m_full = 1'b0;
      end
      #1;
      check_val("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
         check_val("rsp_id", 32'(rsp_id), 32'(m_id));
         check_val("rsp_result", rsp_result, m_res);
         check_val("rsp_zero", 32'(rsp_zero), 32'(m_zero));
      end
      @(negedge clk);
   endtask

   task automatic expect_rsp(input string tag, input logic id, input logic [31:0] res, input logic zero);
      check_val({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check_val({tag, "_id"}, 32'(rsp_id), 32'(id));
      check_val({tag, "_result"}, rsp_result, res);
      check_val({tag, "_zero"}, 32'(rsp_zero), 32'(zero));
   endtask

   initial begin
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
      set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
      model_reset();
      #2;
      check_val("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("reset_rsp_result", rsp_result, 32'd0);
      check_val("reset_req0_ready", 32'(req0_ready), 32'd0);
      check_val("reset_alu_enable", 32'(alu_enable), 32'd0);
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;

      // Tie after reset: requester 0 first, then requester 1.
      set_req(0, 1'b1, ALU_SUB, 32'd3, 32'd3);
      set_req(1, 1'b1, ALU_OR, 32'h0F, 32'hF0);
      step();
      expect_rsp("tie_c1", 1'b0, 32'd0, 1'b1);
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      step();
      expect_rsp("tie_c2", 1'b1, 32'hFF, 1'b0);

      // Persistent tie: alternation or fixed priority.
      set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
      set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);
      for (int i = 0; i < 4; i++) begin
         step();
         if (FIXED_PRIO) expect_rsp("tie_more", 1'b0, 32'd2, 1'b0);
         else            expect_rsp("tie_more", 1'(i % 2), (i % 2 == 1) ? 32'd4 : 32'd2, 1'b0);
      end

      // Idle: drain, nothing driven on the ALU.
      set_req(0, 1'b0, ALU_XOR, 32'd9, 32'd9);
      set_req(1, 1'b0, ALU_XOR, 32'd9, 32'd9);
      step();
      check_val("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("idle_alu_enable", 32'(alu_enable), 32'd0);
      check_val("idle_alu_op", 32'(alu_operation), 32'd0);
      check_val("idle_alu_a", alu_operand_a, 32'd0);
      check_val("idle_alu_b", alu_operand_b, 32'd0);

      // Single op.
      set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
      step();
      expect_rsp("single", 1'b0, 32'd12, 1'b0);

      // Backpressure with the slot full.
      rsp_ready = 1'b0;
      set_req(0, 1'b1, ALU_XOR, 32'hAA, 32'h55);
      set_req(1, 1'b1, ALU_SUB, 32'd9, 32'd4);
      for (int i = 0; i < 5; i++) begin
         step();
         expect_rsp("bp_hold", 1'b0, 32'd12, 1'b0);
         #1;
         check_val("bp_req0_ready", 32'(req0_ready), 32'd0);
         check_val("bp_req1_ready", 32'(req1_ready), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      step();
      if (FIXED_PRIO) expect_rsp("bp_release", 1'b0, 32'hFF, 1'b0);
      else            expect_rsp("bp_release", 1'b1, 32'd5, 1'b0);

      // Back-to-back from requester 1.
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1'b1, ALU_ADD, 32'(100 + i), 32'(i));
         step();
         expect_rsp("b2b", 1'b1, 32'(100 + 2 * i), 1'b0);
      end

      // Reset while a response is held.
      set_req(0, 1'b1, ALU_AND, 32'hF0, 32'h3C);
      set_req(1, 1'b1, ALU_OR, 32'h01, 32'h02);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_val("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_mid_result", rsp_result, 32'd0);
      check_val("rst_mid_id", 32'(rsp_id), 32'd0);
      check_val("rst_mid_zero", 32'(rsp_zero), 32'd0);
      check_val("rst_mid_ready0", 32'(req0_ready), 32'd0);
      check_val("rst_mid_ready1", 32'(req1_ready), 32'd0);
      check_val("rst_mid_alu_en", 32'(alu_enable), 32'd0);
      @(negedge clk);
      step();
      rst_n = 1'b1;
      step();
      expect_rsp("rst_tie", 1'b0, 32'h30, 1'b0);

      // Randomized traffic; requesters hold payload until accepted.
      for (int c = 0; c < 600; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (!req0_valid || acc0) begin
            set_req(0, ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 5)),
                    32'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7)));
         end
         if (!req1_valid || acc1) begin
            set_req(1, ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 5)),
                    $urandom, 32'($urandom_range(0, 7)));
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
